// File: rtl/mock_cu_multi.sv
// Mock control unit that emulates NUM_DEVICES consecutive I/O devices on a byte channel:
// selection, command decode, initial/ending status, read/write/sense data transfer.
module mock_cu_multi #(
    parameter logic [7:0] BASE_ADDRESS      = 8'h10,
    parameter int         NUM_DEVICES       = 4,
    parameter bit         ENABLE_SHORT_BUSY = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   operational_out,
    input  logic                   address_out,
    input  logic                   command_out,
    input  logic                   service_out,
    input  logic                   suppress_out,
    input  logic [7:0]             bus_out,
    input  logic                   selection_x,
    output logic [7:0]             bus_in,
    output logic                   operational_in,
    output logic                   address_in,
    output logic                   status_in,
    output logic                   service_in,
    output logic                   request_in,
    output logic                   selection_y,
    input  logic [NUM_DEVICES-1:0] mock_busy,
    input  logic [15:0]            mock_limit,
    output logic [7:0]             command,
    output logic [3:0]             device,
    output logic [15:0]            count
);
    localparam logic [7:0] CMD_TEST  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] CMD_NOP   = 8'h03;
    localparam logic [7:0] CMD_SENSE = 8'h04;
    localparam logic [7:0] STAT_END  = 8'h30;
    localparam logic [7:0] STAT_BUSY = 8'h08;
    localparam logic [7:0] STAT_REJ  = 8'h70;
    localparam logic [7:0] STAT_SB   = 8'h0A;
    localparam logic [8:0] NUM_DEV9  = 9'(NUM_DEVICES);

    typedef enum logic [3:0] {
        S_IDLE, S_SHORT_BUSY, S_SB_DROP, S_SEL, S_ADDR_IN, S_CMD_DROP, S_DECODE,
        S_INIT_STATUS, S_INIT_DROP, S_RD_XFER, S_WR_XFER, S_XFER_DROP, S_STOP_WAIT,
        S_SENSE_XFER, S_SENSE_DROP, S_END_STATUS
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  device_reg, device_next;
    logic [7:0]  command_reg, command_next;
    logic [15:0] count_reg, count_next;
    logic [7:0]  status_reg, status_next;
    logic [7:0]  sense_reg [16];
    logic [7:0]  checksum_reg [16];
    logic        sense_set, sense_clear, chk_update;
    logic [7:0]  bus_in_next;
    logic        operational_in_next, address_in_next, status_in_next;
    logic        service_in_next, selection_y_next;

    logic [15:0] busy_ext;
    logic [8:0]  addr_offset;
    logic        in_range;

    // Pad the per-device busy vector to 16 so any 4-bit device index is a legal select.
    for (genvar gi = 0; gi < 16; gi++) begin : g_busy
        if (gi < NUM_DEVICES) begin : g_dev
            assign busy_ext[gi] = mock_busy[gi];
        end else begin : g_pad
            assign busy_ext[gi] = 1'b0;
        end
    end

    assign addr_offset = {1'b0, bus_out} - {1'b0, BASE_ADDRESS};
    assign in_range    = (bus_out >= BASE_ADDRESS) && (addr_offset < NUM_DEV9);
    assign request_in  = 1'b0;
    assign command     = command_reg;
    assign device      = device_reg;
    assign count       = count_reg;

    always_comb begin
        state_next   = state_reg;
        device_next  = device_reg;
        command_next = command_reg;
        count_next   = count_reg;
        status_next  = status_reg;
        sense_set    = 1'b0;
        sense_clear  = 1'b0;
        chk_update   = 1'b0;
        if (!operational_out) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: if (address_out && selection_x && in_range) begin
                    device_next = addr_offset[3:0];
                    state_next  = (busy_ext[addr_offset[3:0]] && ENABLE_SHORT_BUSY) ? S_SHORT_BUSY : S_SEL;
                end
                S_SHORT_BUSY: if (service_out) state_next = S_SB_DROP;
                S_SB_DROP:    if (!address_out && !service_out) state_next = S_IDLE;
                S_SEL:        if (!address_out) state_next = S_ADDR_IN;
                S_ADDR_IN: if (command_out) begin
                    command_next = bus_out;
                    state_next   = S_CMD_DROP;
                end
                S_CMD_DROP: if (!command_out) state_next = S_DECODE;
                S_DECODE: begin
                    state_next = S_INIT_STATUS;
                    if (busy_ext[device_reg]) status_next = STAT_BUSY;
                    else begin
                        case (command_reg)
                            CMD_TEST, CMD_NOP:             status_next = STAT_END;
                            CMD_WRITE, CMD_READ, CMD_SENSE: status_next = 8'h00;
                            default: begin
                                status_next = STAT_REJ;
                                sense_set   = 1'b1;
                            end
                        endcase
                    end
                end
                // A command tag in place of service means the channel stacked the status.
                S_INIT_STATUS: begin
                    if (service_out)      state_next = S_INIT_DROP;
                    else if (command_out) state_next = S_IDLE;
                end
                S_INIT_DROP: if (!service_out) begin
                    if (status_reg[3] || status_reg[5]) state_next = S_IDLE;
                    else begin
                        count_next  = '0;
                        status_next = STAT_END;
                        case (command_reg)
                            CMD_WRITE: state_next = (mock_limit == 16'd0) ? S_END_STATUS : S_WR_XFER;
                            CMD_READ:  state_next = (mock_limit == 16'd0) ? S_END_STATUS : S_RD_XFER;
                            CMD_SENSE: state_next = S_SENSE_XFER;
                            default:   state_next = S_IDLE;
                        endcase
                    end
                end
                S_RD_XFER, S_WR_XFER: begin
                    if (command_out) state_next = S_STOP_WAIT;
                    else if (service_out && service_in) begin
                        count_next = count_reg + 16'd1;
                        chk_update = (state_reg == S_WR_XFER);
                        state_next = S_XFER_DROP;
                    end
                end
                S_XFER_DROP: if (!service_out) begin
                    if (count_reg == mock_limit)     state_next = S_END_STATUS;
                    else if (command_reg == CMD_WRITE) state_next = S_WR_XFER;
                    else                             state_next = S_RD_XFER;
                end
                S_STOP_WAIT: if (!command_out) begin
                    status_next = STAT_END;
                    state_next  = S_END_STATUS;
                end
                S_SENSE_XFER: if (service_out && service_in) begin
                    sense_clear = 1'b1;
                    state_next  = S_SENSE_DROP;
                end
                S_SENSE_DROP: if (!service_out) state_next = S_END_STATUS;
                S_END_STATUS: if (service_out) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end

        // Tags and bus are decoded from the next state so they line up with the state register.
        operational_in_next = !(state_next inside {S_IDLE, S_SB_DROP});
        status_in_next      = state_next inside {S_SHORT_BUSY, S_INIT_STATUS, S_END_STATUS};
        address_in_next     = (state_next == S_ADDR_IN);
        service_in_next     = (state_next inside {S_RD_XFER, S_WR_XFER, S_SENSE_XFER}) && !suppress_out;
        selection_y_next    = (state_next == S_IDLE) ? selection_x : 1'b0;
        case (state_next)
            S_SHORT_BUSY:                 bus_in_next = STAT_SB;
            S_ADDR_IN:                    bus_in_next = BASE_ADDRESS + {4'b0, device_next};
            S_INIT_STATUS, S_END_STATUS:  bus_in_next = status_next;
            S_RD_XFER:                    bus_in_next = (count_next[7:0] + 8'd1) ^ {4'b0, device_next};
            S_SENSE_XFER:                 bus_in_next = sense_reg[device_next];
            default:                      bus_in_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            device_reg     <= '0;
            command_reg    <= '0;
            count_reg      <= '0;
            status_reg     <= STAT_END;
            bus_in         <= '0;
            operational_in <= 1'b0;
            address_in     <= 1'b0;
            status_in      <= 1'b0;
            service_in     <= 1'b0;
            selection_y    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                sense_reg[i]    <= '0;
                checksum_reg[i] <= '0;
            end
        end else begin
            state_reg      <= state_next;
            device_reg     <= device_next;
            command_reg    <= command_next;
            count_reg      <= count_next;
            status_reg     <= status_next;
            bus_in         <= bus_in_next;
            operational_in <= operational_in_next;
            address_in     <= address_in_next;
            status_in      <= status_in_next;
            service_in     <= service_in_next;
            selection_y    <= selection_y_next;
            if (sense_set)   sense_reg[device_reg] <= sense_reg[device_reg] | 8'h01;
            if (sense_clear) sense_reg[device_reg] <= 8'h00;
            if (chk_update)  checksum_reg[device_reg] <= checksum_reg[device_reg] ^ bus_out;
        end
    end
endmodule

// File: tb/tb_mock_cu_multi.sv
// Directed bench for mock_cu_multi: table of select/command/initial-status vectors plus
// hand-written sequences for short busy, data transfer, stop, sense and reset corners.
module tb_mock_cu_multi;
    logic        clk = 1'b0;
    logic        reset;
    logic        operational_out, address_out, command_out, service_out, suppress_out;
    logic [7:0]  bus_out;
    logic        selection_x;
    logic [7:0]  bus_in;
    logic        operational_in, address_in, status_in, service_in, request_in, selection_y;
    logic [3:0]  mock_busy;
    logic [15:0] mock_limit;
    logic [7:0]  command;
    logic [3:0]  device;
    logic [15:0] count;

    int checks = 0;
    int errors = 0;
    bit addr_in_seen, svc_seen;

    localparam int T_OP = 0, T_ADDR = 1, T_STAT = 2, T_SVC = 3;

    mock_cu_multi #(.BASE_ADDRESS(8'h10), .NUM_DEVICES(4), .ENABLE_SHORT_BUSY(1'b1)) dut (
        .clk(clk), .reset(reset),
        .operational_out(operational_out), .address_out(address_out), .command_out(command_out),
        .service_out(service_out), .suppress_out(suppress_out), .bus_out(bus_out),
        .selection_x(selection_x), .bus_in(bus_in), .operational_in(operational_in),
        .address_in(address_in), .status_in(status_in), .service_in(service_in),
        .request_in(request_in), .selection_y(selection_y), .mock_busy(mock_busy),
        .mock_limit(mock_limit), .command(command), .device(device), .count(count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (address_in) addr_in_seen = 1'b1;
        if (service_in) svc_seen = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_tag(input int sel);
        case (sel)
            T_OP:    return operational_in;
            T_ADDR:  return address_in;
            T_STAT:  return status_in;
            default: return service_in;
        endcase
    endfunction

    task automatic wait_tag(input int sel, input logic val, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < 64 && !hit; i++) begin
            @(negedge clk);
            if (get_tag(sel) === val) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_%s: got timeout expected tag=%0b", name, val);
        end
    endtask

    task automatic select_and_cmd(input logic [7:0] addr, input logic [7:0] cmd,
                                  input logic [3:0] late_busy, output logic [7:0] st);
        @(negedge clk);
        bus_out = addr; address_out = 1'b1; selection_x = 1'b1;
        wait_tag(T_OP, 1'b1, "op_in");
        check("sel_y_blocked", 32'(selection_y), 32'h0);
        address_out = 1'b0; bus_out = 8'h00;
        wait_tag(T_ADDR, 1'b1, "addr_in");
        check("addr_echo", 32'(bus_in), 32'(addr));
        mock_busy = late_busy;
        bus_out = cmd; command_out = 1'b1;
        wait_tag(T_ADDR, 1'b0, "addr_drop");
        command_out = 1'b0; bus_out = 8'h00;
        wait_tag(T_STAT, 1'b1, "init_status");
        st = bus_in;
        service_out = 1'b1;
        wait_tag(T_STAT, 1'b0, "init_status_drop");
        service_out = 1'b0;
        $display("select %h cmd %h -> initial status %h", addr, cmd, st);
    endtask

    task automatic xfer_byte(input logic [7:0] wr_data, output logic [7:0] rd_data);
        wait_tag(T_SVC, 1'b1, "svc_in");
        rd_data = bus_in;
        bus_out = wr_data; service_out = 1'b1;
        wait_tag(T_SVC, 1'b0, "svc_drop");
        service_out = 1'b0; bus_out = 8'h00;
        $display("data byte in=%h out=%h count=%0d", rd_data, wr_data, count);
    endtask

    task automatic end_status(output logic [7:0] st);
        wait_tag(T_STAT, 1'b1, "end_status");
        st = bus_in;
        service_out = 1'b1;
        wait_tag(T_STAT, 1'b0, "end_status_drop");
        service_out = 1'b0; selection_x = 1'b0;
        $display("ending status %h count=%0d device=%0d", st, count, device);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] cmd;
        logic [3:0] late_busy;
        logic [7:0] exp_status;
        logic [3:0] exp_dev;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] st, d;
        vecs[0] = '{8'h12, 8'h03, 4'b0000, 8'h30, 4'd2};   // NOP
        vecs[1] = '{8'h10, 8'h00, 4'b0000, 8'h30, 4'd0};   // TEST I/O
        vecs[2] = '{8'h10, 8'hAA, 4'b0000, 8'h70, 4'd0};   // reject, sets sense bit 0
        vecs[3] = '{8'h13, 8'h05, 4'b0000, 8'h70, 4'd3};
        vecs[4] = '{8'h11, 8'h03, 4'b0010, 8'h08, 4'd1};   // busy raised after selection

        reset = 1'b1; operational_out = 1'b1; address_out = 1'b0; command_out = 1'b0;
        service_out = 1'b0; suppress_out = 1'b0; bus_out = 8'h00; selection_x = 1'b0;
        mock_busy = 4'b0000; mock_limit = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_tags", {27'b0, operational_in, address_in, status_in, service_in, request_in}, 32'h0);
        check("rst_bus_in", 32'(bus_in), 32'h0);
        check("rst_sel_y", 32'(selection_y), 32'h0);
        check("rst_regs", {command, device, count}, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            select_and_cmd(vecs[i].addr, vecs[i].cmd, vecs[i].late_busy, st);
            check("init_status", 32'(st), 32'(vecs[i].exp_status));
            selection_x = 1'b0; mock_busy = 4'b0000;
            repeat (3) @(negedge clk);
            check("back_idle", 32'(operational_in), 32'h0);
            check("device", 32'(device), 32'(vecs[i].exp_dev));
            check("command", 32'(command), 32'(vecs[i].cmd));
        end

        // Short busy: busy device at selection never presents its address
        mock_busy = 4'b0010; addr_in_seen = 1'b0;
        @(negedge clk);
        bus_out = 8'h11; address_out = 1'b1; selection_x = 1'b1;
        wait_tag(T_STAT, 1'b1, "sb_status");
        check("sb_bus_in", 32'(bus_in), 32'h0A);
        check("sb_op_in", 32'(operational_in), 32'h1);
        service_out = 1'b1;
        wait_tag(T_STAT, 1'b0, "sb_status_drop");
        check("sb_op_drop", 32'(operational_in), 32'h0);
        service_out = 1'b0; address_out = 1'b0; selection_x = 1'b0; bus_out = 8'h00;
        repeat (3) @(negedge clk);
        check("sb_no_addr_in", 32'(addr_in_seen), 32'h0);
        check("sb_device", 32'(device), 32'h1);
        check("sb_idle", 32'(operational_in), 32'h0);
        $display("short busy select 11 handled, device=%0d", device);
        mock_busy = 4'b0000;

        // Out-of-range address passes selection through
        @(negedge clk);
        bus_out = 8'h20; address_out = 1'b1; selection_x = 1'b1;
        repeat (3) @(negedge clk);
        check("oor_sel_y", 32'(selection_y), 32'h1);
        check("oor_tags", {30'b0, operational_in, address_in}, 32'h0);
        selection_x = 1'b0;
        repeat (2) @(negedge clk);
        check("oor_sel_y_low", 32'(selection_y), 32'h0);
        address_out = 1'b0; bus_out = 8'h00;
        $display("select 20 out of range, selection passed on");

        // READ, limit 3, with suppress held between bytes
        mock_limit = 16'd3;
        select_and_cmd(8'h10, 8'h02, 4'b0000, st);
        check("rd_init", 32'(st), 32'h00);
        xfer_byte(8'h00, d); check("rd_b1", 32'(d), 32'h01);
        suppress_out = 1'b1;
        repeat (4) @(negedge clk);
        check("rd_suppress", 32'(service_in), 32'h0);
        suppress_out = 1'b0;
        xfer_byte(8'h00, d); check("rd_b2", 32'(d), 32'h02);
        xfer_byte(8'h00, d); check("rd_b3", 32'(d), 32'h03);
        end_status(st);
        check("rd_end", 32'(st), 32'h30);
        check("rd_count", 32'(count), 32'd3);

        // READ with zero limit moves no data
        mock_limit = 16'd0; svc_seen = 1'b0;
        select_and_cmd(8'h11, 8'h02, 4'b0000, st);
        check("z_init", 32'(st), 32'h00);
        end_status(st);
        check("z_end", 32'(st), 32'h30);
        check("z_no_svc", 32'(svc_seen), 32'h0);
        check("z_count", 32'(count), 32'd0);

        // WRITE, limit 8, stopped by the channel after 2 bytes
        mock_limit = 16'd8;
        select_and_cmd(8'h13, 8'h01, 4'b0000, st);
        check("wr_init", 32'(st), 32'h00);
        xfer_byte(8'h5A, d);
        xfer_byte(8'hC3, d);
        wait_tag(T_SVC, 1'b1, "wr_svc3");
        command_out = 1'b1;
        wait_tag(T_SVC, 1'b0, "wr_stop");
        command_out = 1'b0;
        end_status(st);
        check("wr_end", 32'(st), 32'h30);
        check("wr_count", 32'(count), 32'd2);
        check("wr_device", 32'(device), 32'd3);

        // SENSE after the earlier reject on device 0, then again after it cleared
        for (int k = 0; k < 2; k++) begin
            select_and_cmd(8'h10, 8'h04, 4'b0000, st);
            check("sn_init", 32'(st), 32'h00);
            xfer_byte(8'h00, d);
            check("sn_byte", 32'(d), (k == 0) ? 32'h01 : 32'h00);
            end_status(st);
            check("sn_end", 32'(st), 32'h30);
        end

        // Dropping operational_out abandons the selection
        @(negedge clk);
        bus_out = 8'h12; address_out = 1'b1; selection_x = 1'b1;
        wait_tag(T_OP, 1'b1, "opd_op_in");
        address_out = 1'b0; bus_out = 8'h00;
        wait_tag(T_ADDR, 1'b1, "opd_addr_in");
        operational_out = 1'b0;
        @(negedge clk);
        check("opd_tags", {30'b0, operational_in, address_in}, 32'h0);
        selection_x = 1'b0; operational_out = 1'b1;
        repeat (2) @(negedge clk);
        $display("operational_out drop forced idle");

        // Reset in the middle of a read transfer
        mock_limit = 16'd5;
        select_and_cmd(8'h12, 8'h02, 4'b0000, st);
        xfer_byte(8'h00, d); check("mr_b1", 32'(d), 32'h03);
        wait_tag(T_SVC, 1'b1, "mr_svc2");
        check("mr_b2", 32'(bus_in), 32'h00);
        reset = 1'b1; selection_x = 1'b0;
        @(negedge clk);
        check("mr_tags", {28'b0, operational_in, address_in, status_in, service_in}, 32'h0);
        check("mr_count", 32'(count), 32'h0);
        reset = 1'b0; svc_seen = 1'b0;
        begin
            bit saw = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (status_in || operational_in) saw = 1'b1;
            end
            check("mr_no_end_status", 32'(saw), 32'h0);
        end
        $display("reset mid-transfer abandoned read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mock_cu_multi.md
MOCK_CU_MULTI -- requirements
Module: mock_cu_multi

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 8'h10, first device address responded to.
REQ-002 SHALL have parameter NUM_DEVICES, default 4, legal 1..16, number of consecutive addresses emulated (BASE_ADDRESS..BASE_ADDRESS+NUM_DEVICES-1, no wrap past 8'hFF).
REQ-003 SHALL have parameter ENABLE_SHORT_BUSY, default 1, 1 = busy device answers with short-busy sequence.
REQ-004 SHALL have ports: clk in 1, clock; reset in 1, synchronous active-high reset.
REQ-005 SHALL have ports: operational_out, address_out, command_out, service_out, suppress_out, each in 1, channel tags.
REQ-006 SHALL have ports: bus_out in 8, channel data; selection_x in 1, incoming select.
REQ-007 SHALL have ports: bus_in out 8; operational_in, address_in, status_in, service_in, request_in, each out 1, CU tags.
REQ-008 SHALL have port selection_y out 1, select propagated onward.
REQ-009 SHALL have ports: mock_busy in NUM_DEVICES, per-device busy; mock_limit in 16, transfer byte limit.
REQ-010 SHALL have ports: command out 8, last command; device out 4, last selected index; count out 16, bytes moved.

Function
REQ-011 SHALL register all outputs on posedge clk; request_in held 0.
REQ-012 SHALL force state IDLE whenever operational_out=0, except that reset has priority.
REQ-013 In IDLE: selection_y SHALL follow selection_x; on address_out & selection_x & bus_out in range, SHALL drive selection_y=0, latch device=bus_out-BASE_ADDRESS, then go to SHORT_BUSY if mock_busy[device] & ENABLE_SHORT_BUSY, else SEL.
REQ-014 SHORT_BUSY: operational_in=1, status_in=1, bus_in=8'h0A (BUSY+SM) held until service_out, then drop status_in and operational_in, wait !address_out & !service_out, return IDLE; no command accepted.
REQ-015 SEL: operational_in=1; on !address_out -> ADDR_IN.
REQ-016 ADDR_IN: bus_in=BASE_ADDRESS+device, address_in=1; on command_out latch command=bus_out, clear address_in -> CMD_DROP.
REQ-017 CMD_DROP: on !command_out -> DECODE.
REQ-018 DECODE, one cycle, status priority: mock_busy[device] -> 8'h08; 8'h00 TEST I/O -> 8'h30; 8'h01 WRITE or 8'h02 READ -> 8'h00; 8'h03 NOP -> 8'h30; 8'h04 SENSE -> 8'h00; else 8'h70 and set sense_reg[device][0] (command reject).
REQ-019 INIT_STATUS: bus_in=status, status_in=1; on service_out clear status_in -> INIT_DROP; on command_out instead (stack), clear status_in, return IDLE, no state change for device.
REQ-020 INIT_DROP: on !service_out: status BUSY or CE set -> IDLE; WRITE -> WR_XFER; READ -> RD_XFER; SENSE -> SENSE_XFER; count cleared to 0 on any data entry.
REQ-021 RD_XFER: when suppress_out=0, bus_in=count[7:0]+1 xor device, service_in=1; suppress_out=1 SHALL hold service_in low without losing place.
REQ-022 WR_XFER: same handshake, bus_out sampled into per-device checksum (xor) on service_out.
REQ-023 On service_out in XFER: count+=1, clear service_in -> XFER_DROP; on !service_out: count==mock_limit -> END_STATUS (8'h30), else back to XFER.
REQ-024 command_out during any XFER (STOP): clear service_in -> STOP_WAIT; on !command_out -> END_STATUS with 8'h30.
REQ-025 mock_limit=0 SHALL transfer zero bytes; first XFER entry checks limit and goes directly to END_STATUS.
REQ-026 SENSE_XFER: one byte sense_reg[device]; sense_reg[device] cleared after acceptance; then END_STATUS 8'h30.
REQ-027 END_STATUS: operational_in=1, bus_in=status, status_in=1; on service_out clear status_in -> IDLE.
REQ-028 count SHALL wrap 16'hFFFF -> 0 without error.

Reset
REQ-029 Reset SHALL set state=IDLE, all tag outputs 0, bus_in=0, selection_y=0, command=0, device=0, count=0, status=8'h30, all sense_reg=0, all checksums=0; mid-transfer reset abandons it without end status.

Verification
REQ-030 Select 8'h12, NOP, !busy -> address_in with bus_in=8'h12, status 8'h30, return IDLE, device=2.
REQ-031 Select 8'h11, mock_busy=4'b0010, ENABLE_SHORT_BUSY=1 -> status_in with 8'h0A, no address_in, IDLE.
REQ-032 READ to 8'h10, mock_limit=3 -> bytes 01,02,03 then status 8'h30, count=3.
REQ-033 WRITE to 8'h13, mock_limit=8, command_out after 2 bytes -> STOP_WAIT, status 8'h30, count=2.
REQ-034 Command 8'hAA to 8'h10, then SENSE -> status 8'h70, sense byte 8'h01, repeat SENSE gives 8'h00.
REQ-035 Select 8'h20 (out of range) -> selection_y follows selection_x, no tag raised.
